// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: valid/ready word in, MSB-first bit stream out with frame strobes.
// Optional even-parity trailer cycle enabled by defining PISO_PARITY_EN.
module piso_serializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] parallel_in_i,
    output logic             serial_out_o,
    output logic             serial_valid_o,
    output logic             frame_start_o,
    output logic             frame_last_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_bit;
    logic              accept;
`ifdef PISO_PARITY_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        last_bit = (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));
`ifdef PISO_PARITY_EN
        frame_last_o = (state_q == StPar);
`else
        frame_last_o = last_bit;
`endif
        in_ready_o = (state_q == StIdle) || frame_last_o;
        accept     = in_valid_i && in_ready_o;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: ;
            StShift: begin
                if (!last_bit) begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CntW'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = StPar;
`else
                    state_d = StIdle;
`endif
                end
            end
            StPar:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // An accept only happens in IDLE or on the frame's last cycle, so it overrides the above.
        if (accept) begin
            state_d = StShift;
            shift_d = parallel_in_i;
            cnt_d   = '0;
        end
    end

`ifdef PISO_PARITY_EN
    always_comb begin
        par_d = accept ? ^parallel_in_i : par_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode directly from state registers; no input-to-output path except in_ready.
    always_comb begin
        serial_out_o   = 1'b0;
        serial_valid_o = (state_q != StIdle);
        busy_o         = (state_q != StIdle);
        frame_start_o  = (state_q == StShift) && (cnt_q == '0);
        if (state_q == StShift) begin
            serial_out_o = shift_q[WIDTH-1];
        end
`ifdef PISO_PARITY_EN
        if (state_q == StPar) begin
            serial_out_o = par_q;
        end
`endif
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: a driver predicts accepts and pushes expected frame bits,
// a negedge monitor pops and compares whenever serial_valid is high.
module tb_piso_serializer;

    localparam int unsigned WIDTH = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] parallel_in_i = '0;
    logic             serial_out_o;
    logic             serial_valid_o;
    logic             frame_start_o;
    logic             frame_last_o;
    logic             busy_o;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .parallel_in_i  (parallel_in_i),
        .serial_out_o   (serial_out_o),
        .serial_valid_o (serial_valid_o),
        .frame_start_o  (frame_start_o),
        .frame_last_o   (frame_last_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Each entry is {bit, frame_start, frame_last} for one frame cycle.
    logic [2:0] exp_q[$];

    int rem      = 0;     // frame cycles left including the current one
    bit acc_prev = 1'b0;  // accept predicted for the coming edge

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            exp_q.push_back({w[i], (i == WIDTH - 1), (FL == WIDTH) && (i == 0)});
        end
`ifdef PISO_PARITY_EN
        exp_q.push_back({^w, 1'b0, 1'b1});
`endif
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d);
        @(posedge clk_i);
        #1;
        rem = acc_prev ? FL : ((rem > 0) ? rem - 1 : 0);
        in_valid_i    = v;
        parallel_in_i = d;
        @(negedge clk_i);
        chk("in_ready", in_ready_o, (rem <= 1));
        chk("busy", busy_o, (rem != 0));
        chk("serial_valid", serial_valid_o, (rem != 0));
        acc_prev = v && (rem <= 1);
        if (acc_prev) push_frame(d);
    endtask

    task automatic do_reset();
        #2;
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("rst_outs", {serial_out_o, serial_valid_o, frame_start_o, frame_last_o, busy_o}, 0);
        chk("rst_ready", in_ready_o, 1);
        exp_q.delete();
        rem = 0;
        acc_prev = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (serial_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bit", 1, 0);
                    end else begin
                        chk("frame_bit", {serial_out_o, frame_start_o, frame_last_o},
                            exp_q.pop_front());
                    end
                end else begin
                    chk("idle_outs", {serial_out_o, frame_start_o, frame_last_o}, 0);
                end
            end
        end
    end

    initial begin : driver
        #12;
        chk("async_reset_ready", in_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        // Idle after reset.
        repeat (5) step(1'b0, '0);
        chk("idle_serial_out", serial_out_o, 0);
        // Single word 1011.
        step(1'b1, 4'b1011);
        repeat (6) step(1'b0, '0);
        // Back-to-back A then 5 with in_valid held.
        step(1'b1, 4'hA);
        repeat (FL - 1) step(1'b1, 4'hA);
        step(1'b1, 4'h5);
        repeat (FL - 1) step(1'b1, 4'h5);
        repeat (4) step(1'b0, '0);
        // Reset after the second bit of F.
        step(1'b1, 4'hF);
        step(1'b0, '0);
        step(1'b0, '0);
        do_reset();
        repeat (5) step(1'b0, '0);
        // Word pulsed while busy is ignored.
        step(1'b1, 4'b0111);
        step(1'b0, '0);
        step(1'b1, 4'h3);
        repeat (FL + 2) step(1'b0, '0);
        step(1'b1, 4'b0110);
        repeat (FL + 2) step(1'b0, '0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), WIDTH'($urandom));
        end
        repeat (FL + 3) step(1'b0, '0);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
